// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, constants and helpers for the multi-fetch stage
package fetch_pkg;
  localparam int          ENTRY_W          = 64;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction
endpackage

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - circular fetch queue: multi-push, single pop, flush
module if_fetch_queue
  import fetch_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int QUEUE_DEPTH = 8,
  localparam int PTR_W = clog2(QUEUE_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_flush,
  input  logic                           i_pop,
  input  logic [CNT_W-1:0]               i_push_n,
  input  logic [FETCH_WIDTH*ENTRY_W-1:0] i_push_data,
  output logic [ENTRY_W-1:0]             o_head_data,
  output logic [CNT_W-1:0]               o_count
);

  logic [ENTRY_W-1:0] r_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic               w_pop;

  assign w_pop       = i_pop && !i_flush && (r_count != '0);
  assign o_head_data = r_mem[r_head];
  assign o_count     = r_count;

  // A flush empties the queue by moving head onto tail; new lanes land at tail in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= i_flush ? r_tail : r_head + PTR_W'(w_pop);
      r_tail  <= r_tail + PTR_W'(i_push_n);
      r_count <= (i_flush ? '0 : r_count) - CNT_W'(w_pop) + i_push_n;
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (CNT_W'(i) < i_push_n)
        r_mem[r_tail + PTR_W'(i)] <= i_push_data[i*ENTRY_W +: ENTRY_W];
    end
  end

endmodule

// File: rtl/if_multi_fetch.sv
// rtl/if_multi_fetch.sv - multi-instruction fetch stage with fetch queue; IFQ_BYPASS_EN enables empty-queue bypass
module if_multi_fetch
  import fetch_pkg::*;
#(
  parameter int          FETCH_WIDTH = 2,
  parameter int          QUEUE_DEPTH = 8,
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     STALL,
  input  logic                     Request_Alt_PC,
  input  logic [31:0]              Alt_PC,
  output logic [31:0]              Instr_address_2IM,
  input  logic [32*FETCH_WIDTH-1:0] Instr_fIM,
  output logic [31:0]              Instr1_OUT,
  output logic [31:0]              Instr_PC_OUT,
  output logic [31:0]              Instr_PC_Plus4,
  output logic                     Instr_Valid_OUT
);

  localparam int              CNT_W   = clog2(QUEUE_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0] FW_C    = CNT_W'(FETCH_WIDTH);

  logic [31:0]                    r_fetch_pc;
  logic [31:0]                    w_addr;
  logic [CNT_W-1:0]               w_count;
  logic [ENTRY_W-1:0]             w_head;
  logic                           w_push;
  logic                           w_pop;
  logic                           w_bypass;
  logic [CNT_W-1:0]               w_push_n;
  logic [FETCH_WIDTH*ENTRY_W-1:0] w_lanes;
  logic [FETCH_WIDTH*ENTRY_W-1:0] w_push_data;

  assign w_addr            = Request_Alt_PC ? Alt_PC : r_fetch_pc;
  assign Instr_address_2IM = w_addr;
  assign w_push            = Request_Alt_PC || ((DEPTH_C - w_count) >= FW_C);

`ifdef IFQ_BYPASS_EN
  // Redirect flushes the queue, so the redirect cycle counts as empty for bypass.
  assign w_bypass = w_push && !STALL && (Request_Alt_PC || (w_count == '0));
`else
  assign w_bypass = 1'b0;
`endif

  assign w_pop    = !STALL && !Request_Alt_PC && (w_count != '0) && !w_bypass;
  assign w_push_n = !w_push ? '0 : (w_bypass ? FW_C - CNT_W'(1) : FW_C);

  always_comb begin
    w_lanes     = '0;
    w_push_data = '0;
    for (int i = 0; i < FETCH_WIDTH; i++)
      w_lanes[i*ENTRY_W +: ENTRY_W] = {w_addr + 32'(4*i), Instr_fIM[32*i +: 32]};
    if (w_bypass) begin
      for (int i = 0; i < FETCH_WIDTH-1; i++)
        w_push_data[i*ENTRY_W +: ENTRY_W] = w_lanes[(i+1)*ENTRY_W +: ENTRY_W];
    end else begin
      w_push_data = w_lanes;
    end
  end

  if_fetch_queue #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .i_clk       (CLK),
    .i_rst_n     (RESET),
    .i_flush     (Request_Alt_PC),
    .i_pop       (w_pop),
    .i_push_n    (w_push_n),
    .i_push_data (w_push_data),
    .o_head_data (w_head),
    .o_count     (w_count)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_fetch_pc      <= RESET_PC;
      Instr1_OUT      <= NOP_INSTR;
      Instr_PC_OUT    <= 32'h0;
      Instr_PC_Plus4  <= 32'h0;
      Instr_Valid_OUT <= 1'b0;
    end else begin
      if (w_push)
        r_fetch_pc <= w_addr + 32'(4*FETCH_WIDTH);
      if (!STALL) begin
        if (w_bypass) begin
          Instr1_OUT      <= w_lanes[31:0];
          Instr_PC_OUT    <= w_lanes[63:32];
          Instr_PC_Plus4  <= w_lanes[63:32] + 32'd4;
          Instr_Valid_OUT <= 1'b1;
        end else if (w_pop) begin
          Instr1_OUT      <= w_head[31:0];
          Instr_PC_OUT    <= w_head[63:32];
          Instr_PC_Plus4  <= w_head[63:32] + 32'd4;
          Instr_Valid_OUT <= 1'b1;
        end else begin
          Instr1_OUT      <= NOP_INSTR;
          Instr_PC_OUT    <= 32'h0;
          Instr_PC_Plus4  <= 32'h0;
          Instr_Valid_OUT <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_multi_fetch.sv
// tb/tb_if_multi_fetch.sv - randomized bench for if_multi_fetch against a queue-based reference model
module tb_if_multi_fetch;
  localparam int          FW    = 2;
  localparam int          DEPTH = 8;
  localparam logic [31:0] RPC   = 32'hBFC0_0000;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            RESET;
  logic            STALL;
  logic            Request_Alt_PC;
  logic [31:0]     Alt_PC;
  logic [31:0]     Instr_address_2IM;
  logic [32*FW-1:0] Instr_fIM;
  logic [31:0]     Instr1_OUT;
  logic [31:0]     Instr_PC_OUT;
  logic [31:0]     Instr_PC_Plus4;
  logic            Instr_Valid_OUT;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] m_q [$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_instr, m_pc, m_p4;
  logic        m_valid;

  always #5 CLK = ~CLK;

  if_multi_fetch #(.FETCH_WIDTH(FW), .QUEUE_DEPTH(DEPTH), .RESET_PC(RPC)) u_dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .STALL             (STALL),
    .Request_Alt_PC    (Request_Alt_PC),
    .Alt_PC            (Alt_PC),
    .Instr_address_2IM (Instr_address_2IM),
    .Instr_fIM         (Instr_fIM),
    .Instr1_OUT        (Instr1_OUT),
    .Instr_PC_OUT      (Instr_PC_OUT),
    .Instr_PC_Plus4    (Instr_PC_Plus4),
    .Instr_Valid_OUT   (Instr_Valid_OUT)
  );

  function automatic logic [31:0] im_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  always_comb begin
    Instr_fIM = '0;
    for (int i = 0; i < FW; i++)
      Instr_fIM[32*i +: 32] = im_word(Instr_address_2IM + 32'(4*i));
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fetch_pc = RPC;
    m_instr = 0; m_pc = 0; m_p4 = 0; m_valid = 0;
  endtask

  task automatic model_step(input logic s, input logic a, input logic [31:0] apc);
    logic [31:0] addr;
    logic [63:0] e;
    int          pre;
    bit          push, byp, pop;
    addr = a ? apc : m_fetch_pc;
    pre  = m_q.size();
    push = a || ((DEPTH - pre) >= FW);
    byp  = BYP && push && !s && (a || pre == 0);
    if (a) m_q.delete();
    pop = !s && !a && (pre > 0) && !byp;
    e = '0;
    if (pop) e = m_q.pop_front();
    if (push) begin
      for (int i = 0; i < FW; i++)
        if (!(byp && i == 0))
          m_q.push_back({addr + 32'(4*i), im_word(addr + 32'(4*i))});
      m_fetch_pc = addr + 32'(4*FW);
    end
    if (!s) begin
      if (byp) begin
        m_pc = addr; m_instr = im_word(addr); m_p4 = addr + 4; m_valid = 1;
      end else if (pop) begin
        m_pc = e[63:32]; m_instr = e[31:0]; m_p4 = e[63:32] + 4; m_valid = 1;
      end else begin
        m_pc = 0; m_instr = 0; m_p4 = 0; m_valid = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check_val("instr", Instr1_OUT, m_instr);
    check_val("pc", Instr_PC_OUT, m_pc);
    check_val("pc_plus4", Instr_PC_Plus4, m_p4);
    check_val("valid", {31'b0, Instr_Valid_OUT}, {31'b0, m_valid});
    check_val("count", 32'(u_dut.u_queue.o_count), 32'(m_q.size()));
  endtask

  task automatic step(input logic s, input logic a, input logic [31:0] apc);
    STALL = s; Request_Alt_PC = a; Alt_PC = apc;
    #1;
    check_val("im_addr", Instr_address_2IM, a ? apc : m_fetch_pc);
    @(posedge CLK);
    model_step(s, a, apc);
    #1;
    check_outputs();
  endtask

  initial begin
    logic [31:0] apc;
    RESET = 1'b0; STALL = 1'b0; Request_Alt_PC = 1'b0; Alt_PC = '0;
    model_reset();
    #1;
    check_outputs();
    @(posedge CLK); #1;
    check_outputs();
    RESET = 1'b1;

    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++)  step(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++)  step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h8000_0100);
    for (int i = 0; i < 4; i++)  step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h8000_0100);
    for (int i = 0; i < 2; i++)  step(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++)  step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++)  step(1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 400; i++) begin
      apc = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) apc = 32'hFFFF_FFF0 | (apc & 32'hC);
      step($urandom_range(0, 9) < 3, $urandom_range(0, 11) == 0, apc);
    end

    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0);
    #3;
    RESET = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge CLK); #1;
    RESET = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
